// File: rtl/maj_vote_if.sv
// Request/result bundle for maj_vote_arbiter.
// master = requesters plus result consumer, slave = the arbiter.
interface maj_vote_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ*WIDTH-1:0] c_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      d_out;
  logic [IDW-1:0]        d_id;
  logic                  d_valid;
  logic                  d_ready;
  logic                  busy;
  logic [CNT_W-1:0]      disagree_cnt;

  modport master (
    output req, a_in, b_in, c_in, d_ready,
    input  gnt, d_out, d_id, d_valid, busy, disagree_cnt
  );

  modport slave (
    input  req, a_in, b_in, c_in, d_ready,
    output gnt, d_out, d_id, d_valid, busy, disagree_cnt
  );
endinterface

// File: rtl/maj_vote_arbiter.sv
// Round-robin arbiter sharing one bitwise 3-input majority unit among NREQ requesters.
// Optional disagreement counter is built when MAJ_DISAGREE_CNT_EN is defined.
module maj_vote_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  maj_vote_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_c;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_dOut;
  logic [IDW-1:0]   r_dId;
  logic             r_dValid;
  logic             r_busy;

  logic             w_arbPoint;
  logic             w_hiFound;
  logic             w_loFound;
  logic [IDW-1:0]   w_hiWin;
  logic [IDW-1:0]   w_loWin;
  logic             w_found;
  logic [IDW-1:0]   w_winner;
  logic [WIDTH-1:0] w_maj;

  // Lowest requester above the pointer wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    w_hiFound = 1'b0;
    w_loFound = 1'b0;
    w_hiWin   = '0;
    w_loWin   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i] && (i > int'(r_ptr))) begin
        w_hiFound = 1'b1;
        w_hiWin   = IDW'(i);
      end
      if (bus.req[i] && (i <= int'(r_ptr))) begin
        w_loFound = 1'b1;
        w_loWin   = IDW'(i);
      end
    end
    w_found  = w_hiFound | w_loFound;
    w_winner = w_hiFound ? w_hiWin : w_loWin;
  end

  assign w_arbPoint = (r_state == IDLE) || ((r_state == HOLD) && r_dValid && bus.d_ready);
  assign w_maj      = (r_a & r_b) | (r_a & r_c) | (r_b & r_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ptr    <= IDW'(NREQ - 1);
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_gnt    <= '0;
      r_dOut   <= '0;
      r_dId    <= '0;
      r_dValid <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        IDLE, HOLD: begin
          if (w_arbPoint) begin
            r_dValid <= 1'b0;
            if (w_found) begin
              r_a     <= bus.a_in[w_winner*WIDTH +: WIDTH];
              r_b     <= bus.b_in[w_winner*WIDTH +: WIDTH];
              r_c     <= bus.c_in[w_winner*WIDTH +: WIDTH];
              r_ptr   <= w_winner;
              r_gnt   <= NREQ'(1) << w_winner;
              r_state <= EVAL;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        EVAL: begin
          r_dOut   <= w_maj;
          r_dId    <= r_ptr;
          r_dValid <= 1'b1;
          r_state  <= HOLD;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.d_out   = r_dOut;
  assign bus.d_id    = r_dId;
  assign bus.d_valid = r_dValid;
  assign bus.busy    = r_busy;

`ifdef MAJ_DISAGREE_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_disagree;

  assign w_disagree = |((r_a ^ r_b) | (r_a ^ r_c));

  // Counts each evaluation whose three operands differ anywhere; sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if ((r_state == EVAL) && w_disagree && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.disagree_cnt = r_cnt;
`else
  assign bus.disagree_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/maj_vote_arbiter.md
# maj_vote_arbiter

Sequential controller that shares one WIDTH-bit bitwise 3-input majority unit (d = a&b | a&c | b&c per bit) among NREQ requesters. Round-robin arbitration picks a requester, captures its operand triple, evaluates the majority and presents the result with a ready/valid handshake. It sits between the voting clients (redundant-channel comparators) and the single shared majority datapath, and optionally counts evaluations where the three operands disagree.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- CNT_W, 16, disagreement counter width
- IDW, localparam = $clog2(NREQ), requester index width
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- req  input  NREQ  request per requester, level
- a_in  input  NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
- b_in  input  NREQ*WIDTH  operand b, same packing
- c_in  input  NREQ*WIDTH  operand c, same packing
- gnt  output  NREQ  one-hot, 1-cycle pulse: operands of that requester captured
- d_out  output  WIDTH  majority result
- d_id  output  IDW  index of requester owning d_out
- d_valid  output  1  result valid
- d_ready  input  1  consumer accepts result
- busy  output  1  state != IDLE
- disagree_cnt  output  CNT_W  disagreement count (0 when feature compiled out)

## Operation
- States: IDLE, EVAL, HOLD. Reset: state IDLE, gnt 0, d_out 0, d_id 0, d_valid 0, busy 0, disagree_cnt 0, rr pointer NREQ-1, operand registers 0.
- Arbitration point: IDLE, or HOLD with d_valid&d_ready in the same cycle. If any req bit set, winner = first set bit searching from (ptr+1) mod NREQ upward with wrap; at the edge capture a/b/c of winner, ptr <= winner, gnt <= one-hot(winner), state <= EVAL. No req: IDLE stays IDLE; HOLD with handshake goes IDLE.
- EVAL (1 cycle): gnt high; shared unit evaluates captured operands; at edge d_out <= majority, d_id <= winner, d_valid <= 1, state <= HOLD. gnt returns to 0.
- HOLD: d_valid, d_out, d_id held stable while d_ready=0. Handshake completes on edge with d_valid&d_ready: d_valid <= 0 unless a new capture occurs that edge (new result then appears after EVAL; d_valid low during EVAL).
- req is sampled only at arbitration points; req during EVAL is ignored. Requester holds req and operands until it sees gnt; if req still high in the gnt cycle it is a new request.
- Disagreement: an evaluation disagrees if any bit has a, b, c not all equal ((a^b)|(a^c) != 0). Counter increments once per disagreeing evaluation at the EVAL edge, saturates at all-ones, cleared only by reset.
- Async reset at any point aborts the transaction immediately; captured operands and pending result discarded; outputs take reset values without waiting for clk.

## Timing
- Request sampled at edge 0 -> gnt high in cycle 1 -> d_valid high from cycle 2.
- Peak throughput with d_ready=1 and continuous req: one result per 2 cycles.
- Outputs all registered; no combinational path from req/d_ready to gnt/d_valid.

## Configuration
- MAJ_DISAGREE_CNT_EN defined: disagreement detector and saturating CNT_W counter built; disagree_cnt reflects count.
- Undefined: detector and counter omitted; disagree_cnt tied to 0; all other behaviour identical.

## Test plan
- Single request: NREQ=4, WIDTH=8, req=0001, a=0xF0 b=0xCC c=0xAA, d_ready=1 -> gnt=0001 in cycle 1, d_valid=1 in cycle 2 with d_out=0xE8, d_id=0; busy falls after handshake.
- Round-robin: req=1111 held, d_ready=1 -> gnt order 0001,0010,0100,1000,0001 one every 2 cycles; req=1010 from reset -> grants 1,3,1,3.
- Backpressure: d_ready=0 for 5 cycles while req=0100 pending -> d_valid/d_out/d_id stable, no gnt; d_ready=1 -> handshake and gnt=0100 on the same edge, next d_valid 2 cycles later.
- Counter (macro on): evals (0x55,0x55,0x55), (0x00,0x01,0x00), (0xFF,0x7F,0xFF) -> disagree_cnt=2, d_out=0x55,0x00,0xFF; CNT_W=2 with 5 disagreeing evals -> 3. Macro off -> stays 0.
- Async reset: assert rst mid-cycle in HOLD -> d_valid, busy, gnt drop to 0 before next edge; after release req=1111 -> first gnt=0001.
